// File: rtl/correlate_cos_sin_bank.sv
// rtl/correlate_cos_sin_bank.sv - banked cos/sin correlation accumulators with sticky overflow and readback.
// Optional macro CORRELATOR_SATURATE_EN: saturate a carrying component at all-ones instead of wrapping.
module correlate_cos_sin_bank #(
    parameter int ACCUM = 24,
    parameter int BANKS = 4,
    parameter int ABITS = 2,
    parameter int SUMHI = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ABITS-1:0] addr,
    input  logic             clr,
    input  logic             hi,
    input  logic             ar,
    input  logic             br,
    input  logic             bi,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    output logic             qvld,
    output logic [ACCUM-1:0] qcos,
    output logic [ACCUM-1:0] qsin,
    output logic             qovf
);

    logic             s1_vld_q, s1_vld_d;
    logic [ABITS-1:0] s1_addr_q, s1_addr_d;
    logic             s1_clr_q, s1_clr_d;
    logic             s1_c0_q, s1_c0_d;
    logic             s1_c1_q, s1_c1_d;

    logic [ACCUM-1:0] cos_q [BANKS];
    logic [ACCUM-1:0] sin_q [BANKS];
    logic [BANKS-1:0] ovf_q;

    logic             qvld_q;
    logic [ACCUM-1:0] qcos_q, qsin_q;
    logic             qovf_q;

    logic [ACCUM:0]   sum_cos, sum_sin;
    logic [ACCUM-1:0] wr_cos, wr_sin;
    logic             wr_ovf;

    always_comb begin
        s1_vld_d  = en;
        s1_addr_d = addr;
        s1_clr_d  = clr;
        if ((SUMHI != 0) && hi) begin
            s1_c0_d = br;
            s1_c1_d = ar;
        end else begin
            s1_c0_d = (ar == br);
            s1_c1_d = (ar == bi);
        end
    end

    // Stage 2 reads the bank combinationally, so a back-to-back sample sees the previous edge's write.
    always_comb begin
        sum_cos = {1'b0, cos_q[s1_addr_q]} + {{ACCUM{1'b0}}, s1_c0_q};
        sum_sin = {1'b0, sin_q[s1_addr_q]} + {{ACCUM{1'b0}}, s1_c1_q};
        wr_cos  = sum_cos[ACCUM-1:0];
        wr_sin  = sum_sin[ACCUM-1:0];
`ifdef CORRELATOR_SATURATE_EN
        if (sum_cos[ACCUM]) wr_cos = '1;
        if (sum_sin[ACCUM]) wr_sin = '1;
`endif
        wr_ovf  = ovf_q[s1_addr_q] | sum_cos[ACCUM] | sum_sin[ACCUM];
        if (s1_clr_q) begin
            wr_cos = {{(ACCUM-1){1'b0}}, s1_c0_q};
            wr_sin = {{(ACCUM-1){1'b0}}, s1_c1_q};
            wr_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_clr_q  <= 1'b0;
            s1_c0_q   <= 1'b0;
            s1_c1_q   <= 1'b0;
            for (int i = 0; i < BANKS; i++) begin
                cos_q[i] <= '0;
                sin_q[i] <= '0;
            end
            ovf_q  <= '0;
            qvld_q <= 1'b0;
            qcos_q <= '0;
            qsin_q <= '0;
            qovf_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s1_clr_q  <= s1_clr_d;
            s1_c0_q   <= s1_c0_d;
            s1_c1_q   <= s1_c1_d;
            if (s1_vld_q) begin
                cos_q[s1_addr_q] <= wr_cos;
                sin_q[s1_addr_q] <= wr_sin;
                ovf_q[s1_addr_q] <= wr_ovf;
            end
            // Readback samples the pre-edge bank state, so a concurrent clear returns the old value.
            qvld_q <= rd_en;
            if (rd_en) begin
                qcos_q <= cos_q[rd_addr];
                qsin_q <= sin_q[rd_addr];
                qovf_q <= ovf_q[rd_addr];
            end
        end
    end

    assign qvld = qvld_q;
    assign qcos = qcos_q;
    assign qsin = qsin_q;
    assign qovf = qovf_q;

endmodule

// File: tb/tb_correlate_cos_sin_bank.sv
// tb/tb_correlate_cos_sin_bank.sv - self-checking bench: 24-bit default instance and 4-bit ones-counting instance.
module tb_correlate_cos_sin_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, clr, hi, ar, br, bi, rd_en;
    logic [1:0] addr, rd_addr;

    logic        qvld0, qovf0, qvld1, qovf1;
    logic [23:0] qcos0, qsin0;
    logic [3:0]  qcos1, qsin1;

    correlate_cos_sin_bank dut0 (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .clr(clr), .hi(hi),
        .ar(ar), .br(br), .bi(bi), .rd_en(rd_en), .rd_addr(rd_addr),
        .qvld(qvld0), .qcos(qcos0), .qsin(qsin0), .qovf(qovf0)
    );

    correlate_cos_sin_bank #(.ACCUM(4), .BANKS(4), .ABITS(2), .SUMHI(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .clr(clr), .hi(hi),
        .ar(ar), .br(br), .bi(bi), .rd_en(rd_en), .rd_addr(rd_addr),
        .qvld(qvld1), .qcos(qcos1), .qsin(qsin1), .qovf(qovf1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: each bank is a pair of integers; sample applies one cycle after capture.
    int unsigned m_cos [2][4];
    int unsigned m_sin [2][4];
    bit          m_ovf [2][4];
    bit          p_vld, p_clr;
    int          p_addr;
    bit          p_c0 [2];
    bit          p_c1 [2];
    bit          e_vld;
    int unsigned e_cos [2];
    int unsigned e_sin [2];
    bit          e_ovf [2];
    bit          active = 1'b0;

    function automatic logic [32:0] add1(int unsigned v, bit c, int w);
        longint unsigned lim = 64'd1 << w;
        longint unsigned n   = longint'(v) + longint'(c);
        if (n >= lim) begin
`ifdef CORRELATOR_SATURATE_EN
            return {1'b1, 32'(lim - 1)};
`else
            return {1'b1, 32'(n - lim)};
`endif
        end
        return {1'b0, 32'(n)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int b = 0; b < 4; b++) begin
                    m_cos[i][b] = 0; m_sin[i][b] = 0; m_ovf[i][b] = 0;
                end
                e_cos[i] = 0; e_sin[i] = 0; e_ovf[i] = 0;
            end
            e_vld = 0;
            p_vld = 0;
        end else begin
            e_vld = rd_en;
            for (int i = 0; i < 2; i++) begin
                if (rd_en) begin
                    e_cos[i] = m_cos[i][rd_addr];
                    e_sin[i] = m_sin[i][rd_addr];
                    e_ovf[i] = m_ovf[i][rd_addr];
                end
                if (p_vld) begin
                    if (p_clr) begin
                        m_cos[i][p_addr] = p_c0[i];
                        m_sin[i][p_addr] = p_c1[i];
                        m_ovf[i][p_addr] = 0;
                    end else begin
                        logic [32:0] rc, rs;
                        rc = add1(m_cos[i][p_addr], p_c0[i], (i == 0) ? 24 : 4);
                        rs = add1(m_sin[i][p_addr], p_c1[i], (i == 0) ? 24 : 4);
                        m_cos[i][p_addr] = rc[31:0];
                        m_sin[i][p_addr] = rs[31:0];
                        if (rc[32] || rs[32]) m_ovf[i][p_addr] = 1;
                    end
                end
            end
            p_vld  = en;
            p_clr  = clr;
            p_addr = addr;
            for (int i = 0; i < 2; i++) begin
                if (i == 1 && hi) begin
                    p_c0[i] = br;
                    p_c1[i] = ar;
                end else begin
                    p_c0[i] = (ar == br);
                    p_c1[i] = (ar == bi);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (active) begin
            chk("qvld24", qvld0, e_vld);
            chk("qcos24", qcos0, e_cos[0]);
            chk("qsin24", qsin0, e_sin[0]);
            chk("qovf24", qovf0, e_ovf[0]);
            chk("qvld4",  qvld1, e_vld);
            chk("qcos4",  qcos1, e_cos[1]);
            chk("qsin4",  qsin1, e_sin[1]);
            chk("qovf4",  qovf1, e_ovf[1]);
        end
    end

    task automatic idle();
        en = 0; clr = 0; rd_en = 0;
        @(negedge clk);
    endtask

    task automatic sample(int a, bit c, bit h, bit xar, bit xbr, bit xbi);
        en = 1; addr = 2'(a); clr = c; hi = h; ar = xar; br = xbr; bi = xbi;
        @(negedge clk);
        en = 0; clr = 0;
    endtask

    task automatic rd_lit(int b, logic [31:0] c0, logic [31:0] s0, logic [31:0] o0,
                          logic [31:0] c1, logic [31:0] s1, logic [31:0] o1);
        rd_en = 1; rd_addr = 2'(b);
        @(negedge clk);
        rd_en = 0;
        chk("lit_qvld24", qvld0, 1);
        chk("lit_qcos24", qcos0, c0);
        chk("lit_qsin24", qsin0, s0);
        chk("lit_qovf24", qovf0, o0);
        chk("lit_qvld4",  qvld1, 1);
        chk("lit_qcos4",  qcos1, c1);
        chk("lit_qsin4",  qsin1, s1);
        chk("lit_qovf4",  qovf1, o1);
    endtask

    initial begin
        rst = 1; en = 0; clr = 0; hi = 0; ar = 0; br = 0; bi = 0;
        rd_en = 0; addr = 0; rd_addr = 0;
        @(negedge clk);
        @(negedge clk);
        active = 1'b1;
        rst = 0;
        idle();
        chk("reset_qvld", qvld0, 0);

        for (int b = 0; b < 4; b++) rd_lit(b, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 10; k++) sample(2, k == 0, 0, 1, 1, 1);
        idle();
        rd_lit(2, 10, 10, 0, 10, 10, 0);
        rd_lit(0, 0, 0, 0, 0, 0, 0);
        rd_lit(1, 0, 0, 0, 0, 0, 0);
        rd_lit(3, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 8; k++) sample(k % 2, 0, 0, 1, 0, 1);
        idle();
        rd_lit(0, 0, 4, 0, 0, 4, 0);
        rd_lit(1, 0, 4, 0, 0, 4, 0);

        for (int k = 0; k < 17; k++) sample(0, k == 0, 0, 1, 1, 1);
        idle();
`ifdef CORRELATOR_SATURATE_EN
        rd_lit(0, 17, 17, 0, 15, 15, 1);
`else
        rd_lit(0, 17, 17, 0, 1, 1, 1);
`endif

        for (int k = 0; k < 6; k++) sample(1, k == 0, 0, 1, 1, 1);
        idle();
        sample(1, 1, 0, 1, 1, 0);
        rd_lit(1, 6, 6, 0, 6, 6, 0);
        rd_lit(1, 1, 0, 0, 1, 0, 0);

        for (int k = 0; k < 5; k++) sample(3, k == 0, 1, 1, 0, 1);
        idle();
        rd_lit(3, 0, 5, 0, 0, 5, 0);
        sample(3, 0, 1, 1, 0, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        rd_lit(3, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom_range(0, 299) == 0);
            en      = ($urandom_range(0, 3) != 0);
            addr    = 2'($urandom_range(0, 3));
            clr     = ($urandom_range(0, 15) == 0);
            hi      = 1'($urandom);
            ar      = 1'($urandom);
            br      = 1'($urandom);
            bi      = 1'($urandom);
            rd_en   = ($urandom_range(0, 2) == 0);
            rd_addr = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        rst = 0;
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
